// File: rtl/fitness_pkg.sv
// Shared widths and FSM encoding for the fitness dispatch slice.
// Imported by fitness_dispatch and fitness_score_ram.
package fitness_pkg;

    localparam int NUM_PARTICLE_TYPE = 3;
    localparam int DATA_WIDTH        = 4;
    localparam int LATTICE_LENGTH    = 11;
    localparam int SELF_FIT_LENGTH   = 10;

    localparam int SELF_ENERGY_VEC_LENGTH =
        NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int INTERATION_MATRIX_LENGTH =
        NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE * DATA_WIDTH;
    localparam int INDIVIDUAL_LENGTH =
        LATTICE_LENGTH * DATA_WIDTH;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/fitness_score_ram.sv
// Score buffer: DEPTH x SELF_FIT_LENGTH, one write port, one registered read.
// Ports: clk_i, rst_i (sync, clears all), wr_en/wr_addr/wr_data, rd_addr -> rd_data.
module fitness_score_ram
    import fitness_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [SELF_FIT_LENGTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]          rd_addr,
    output logic [SELF_FIT_LENGTH-1:0] rd_data
);

    logic [SELF_FIT_LENGTH-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands,
    // so a same-index read/write returns the old score.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en && (int'(wr_addr) < DEPTH)) begin
                mem[wr_addr] <= wr_data;
            end
            if (int'(rd_addr) < DEPTH) begin
                rd_data <= mem[rd_addr];
            end else begin
                rd_data <= '0;
            end
        end
    end

endmodule

// File: rtl/fitness_dispatch.sv
// Issues one population individual at a time to the fitness evaluator and
// stores returned self-fitness scores; pulses done_o after a full sweep.
// Ports: clk_i, rst_i (sync, active-high); cfg_wr_i + energy buses; pop_wr_*
// population load; start_i/busy_o/done_o; eval_* evaluator handshake;
// fit_rd_addr_i -> fit_rd_data_o (1-cycle read).
// Optional: FITNESS_BEST_TRACK_EN adds best_fit_o / best_idx_o.
module fitness_dispatch
    import fitness_pkg::*;
#(
    parameter int POP_SIZE   = 8,
    parameter int POP_ADDR_W = 3
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                cfg_wr_i,
    input  logic [SELF_ENERGY_VEC_LENGTH-1:0]   self_energy_vec_i,
    input  logic [INTERATION_MATRIX_LENGTH-1:0] interact_matrix_i,
    input  logic                                pop_wr_en_i,
    input  logic [POP_ADDR_W-1:0]               pop_wr_addr_i,
    input  logic [INDIVIDUAL_LENGTH-1:0]        pop_wr_data_i,
    input  logic                                start_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                eval_in_valid_o,
    output logic [SELF_ENERGY_VEC_LENGTH-1:0]   eval_self_energy_vec_o,
    output logic [INTERATION_MATRIX_LENGTH-1:0] eval_interact_matrix_o,
    output logic [INDIVIDUAL_LENGTH-1:0]        eval_individual_vec_o,
    input  logic                                eval_out_valid_i,
    input  logic [SELF_FIT_LENGTH-1:0]          eval_self_fit_i,
    input  logic [POP_ADDR_W-1:0]               fit_rd_addr_i,
    output logic [SELF_FIT_LENGTH-1:0]          fit_rd_data_o
`ifdef FITNESS_BEST_TRACK_EN
    ,
    output logic [SELF_FIT_LENGTH-1:0]          best_fit_o,
    output logic [POP_ADDR_W-1:0]               best_idx_o
`endif
);

    localparam logic [POP_ADDR_W-1:0] LAST_IDX =
        POP_ADDR_W'(POP_SIZE - 1);

    state_t                                state;
    logic [POP_ADDR_W-1:0]                 idx;
    logic [INDIVIDUAL_LENGTH-1:0]          pop_mem [POP_SIZE];
    logic [INDIVIDUAL_LENGTH-1:0]          vec_q;
    logic [SELF_ENERGY_VEC_LENGTH-1:0]     se_q;
    logic [INTERATION_MATRIX_LENGTH-1:0]   im_q;

    logic st_idle;
    logic res_take;
    logic pop_we;

    assign st_idle  = (state == ST_IDLE);
    assign res_take = (state == ST_WAIT) && eval_out_valid_i;
    assign pop_we   = st_idle && pop_wr_en_i &&
                      (int'(pop_wr_addr_i) < POP_SIZE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            idx   <= '0;
            vec_q <= '0;
            se_q  <= '0;
            im_q  <= '0;
            for (int i = 0; i < POP_SIZE; i++) begin
                pop_mem[i] <= '0;
            end
        end else begin
            if (pop_we) begin
                pop_mem[pop_wr_addr_i] <= pop_wr_data_i;
            end
            unique case (state)
                ST_IDLE: begin
                    if (cfg_wr_i) begin
                        se_q <= self_energy_vec_i;
                        im_q <= interact_matrix_i;
                    end
                    if (start_i) begin
                        state <= ST_ISSUE;
                        idx   <= '0;
                        vec_q <= pop_mem[0];
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eval_out_valid_i) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            vec_q <= pop_mem[idx + 1'b1];
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o                 = !st_idle;
    assign done_o                 = (state == ST_DONE);
    assign eval_in_valid_o        = (state == ST_ISSUE);
    assign eval_self_energy_vec_o = se_q;
    assign eval_interact_matrix_o = im_q;
    assign eval_individual_vec_o  = vec_q;

    fitness_score_ram #(
        .DEPTH  (POP_SIZE),
        .ADDR_W (POP_ADDR_W)
    ) u_score (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .wr_en   (res_take),
        .wr_addr (idx),
        .wr_data (eval_self_fit_i),
        .rd_addr (fit_rd_addr_i),
        .rd_data (fit_rd_data_o)
    );

`ifdef FITNESS_BEST_TRACK_EN
    logic [SELF_FIT_LENGTH-1:0] best_fit_q;
    logic [POP_ADDR_W-1:0]      best_idx_q;

    // Strict less-than: on ties the earlier (lower) index wins.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            best_fit_q <= '0;
            best_idx_q <= '0;
        end else if (st_idle && start_i) begin
            best_fit_q <= '1;
            best_idx_q <= '0;
        end else if (res_take && (eval_self_fit_i < best_fit_q)) begin
            best_fit_q <= eval_self_fit_i;
            best_idx_q <= idx;
        end
    end

    assign best_fit_o = best_fit_q;
    assign best_idx_o = best_idx_q;
`endif

endmodule

// File: tb/tb_fitness_dispatch.sv
// Self-checking bench for fitness_dispatch: transaction model plus
// directed sweeps with literal expectations.
module tb_fitness_dispatch;
    import fitness_pkg::*;

    localparam int PS  = 8;
    localparam int AW  = 3;
    localparam int SEW = SELF_ENERGY_VEC_LENGTH;
    localparam int IMW = INTERATION_MATRIX_LENGTH;
    localparam int ILW = INDIVIDUAL_LENGTH;
    localparam int FW  = SELF_FIT_LENGTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_i;
    logic           cfg_wr_i;
    logic [SEW-1:0] self_energy_vec_i;
    logic [IMW-1:0] interact_matrix_i;
    logic           pop_wr_en_i;
    logic [AW-1:0]  pop_wr_addr_i;
    logic [ILW-1:0] pop_wr_data_i;
    logic           start_i;
    logic           busy_o;
    logic           done_o;
    logic           eval_in_valid_o;
    logic [SEW-1:0] eval_self_energy_vec_o;
    logic [IMW-1:0] eval_interact_matrix_o;
    logic [ILW-1:0] eval_individual_vec_o;
    logic           eval_out_valid_i;
    logic [FW-1:0]  eval_self_fit_i;
    logic [AW-1:0]  fit_rd_addr_i;
    logic [FW-1:0]  fit_rd_data_o;
`ifdef FITNESS_BEST_TRACK_EN
    logic [FW-1:0]  best_fit_o;
    logic [AW-1:0]  best_idx_o;
`endif

    fitness_dispatch #(.POP_SIZE(PS), .POP_ADDR_W(AW)) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .cfg_wr_i               (cfg_wr_i),
        .self_energy_vec_i      (self_energy_vec_i),
        .interact_matrix_i      (interact_matrix_i),
        .pop_wr_en_i            (pop_wr_en_i),
        .pop_wr_addr_i          (pop_wr_addr_i),
        .pop_wr_data_i          (pop_wr_data_i),
        .start_i                (start_i),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .eval_in_valid_o        (eval_in_valid_o),
        .eval_self_energy_vec_o (eval_self_energy_vec_o),
        .eval_interact_matrix_o (eval_interact_matrix_o),
        .eval_individual_vec_o  (eval_individual_vec_o),
        .eval_out_valid_i       (eval_out_valid_i),
        .eval_self_fit_i        (eval_self_fit_i),
        .fit_rd_addr_i          (fit_rd_addr_i),
        .fit_rd_data_o          (fit_rd_data_o)
`ifdef FITNESS_BEST_TRACK_EN
        ,
        .best_fit_o             (best_fit_o),
        .best_idx_o             (best_idx_o)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, got, exp, $time);
        end
    endtask

    function automatic logic [ILW-1:0] mkind(input int n);
        logic [ILW-1:0] v;
        v = '0;
        for (int k = 0; k < LATTICE_LENGTH; k++) begin
            v[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(n % 3);
        end
        return v;
    endfunction

    // Transaction-level model: a sweep is "start, then for each n an
    // issue strobe followed by one accepted result", then a done cycle.
    logic [ILW-1:0] m_pop   [PS];
    logic [FW-1:0]  m_score [PS];
    logic [SEW-1:0] m_se;
    logic [IMW-1:0] m_im;
    logic [ILW-1:0] m_vec;
    logic [FW-1:0]  m_rd;
    logic [FW-1:0]  m_best;
    int             m_bidx;
    int             m_n;
    bit m_busy, m_strobe, m_done, m_pending;

    always @(posedge clk) begin : model
        bit nb, ns, nd;
        if (rst_i) begin
            for (int i = 0; i < PS; i++) begin
                m_pop[i]   = '0;
                m_score[i] = '0;
            end
            m_se = '0; m_im = '0; m_vec = '0; m_rd = '0;
            m_best = '0; m_bidx = 0; m_n = 0;
            m_busy = 0; m_strobe = 0; m_done = 0; m_pending = 0;
        end else begin
            m_rd = m_score[fit_rd_addr_i];
            nb = m_busy; ns = 0; nd = 0;
            if (m_done) begin
                nb = 0;
            end else if (!m_busy) begin
                if (start_i) begin
                    nb = 1; ns = 1; m_n = 0; m_vec = m_pop[0];
                    m_best = '1; m_bidx = 0;
                end
                if (cfg_wr_i) begin
                    m_se = self_energy_vec_i;
                    m_im = interact_matrix_i;
                end
                if (pop_wr_en_i) m_pop[pop_wr_addr_i] = pop_wr_data_i;
            end else if (m_strobe) begin
                m_pending = 1;
            end else if (m_pending && eval_out_valid_i) begin
                m_score[m_n] = eval_self_fit_i;
                m_pending = 0;
                if (eval_self_fit_i < m_best) begin
                    m_best = eval_self_fit_i; m_bidx = m_n;
                end
                if (m_n == PS - 1) nd = 1;
                else begin
                    m_n++; ns = 1; m_vec = m_pop[m_n];
                end
            end
            m_busy = nb; m_strobe = ns; m_done = nd;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy_o, m_busy);
            chk("in_valid", eval_in_valid_o, m_strobe);
            chk("done", done_o, m_done);
            chk("self_energy", eval_self_energy_vec_o, m_se);
            chk("interact", eval_interact_matrix_o, m_im);
            chk("rd_data", fit_rd_data_o, m_rd);
            if (m_busy) chk("individual", eval_individual_vec_o, m_vec);
`ifdef FITNESS_BEST_TRACK_EN
            chk("best_fit", best_fit_o, m_best);
            chk("best_idx", best_idx_o, m_bidx);
`endif
        end
    end

    // Evaluator stand-in and per-cycle monitor.
    int cyc = 0, eval_d = 1, cd = 0, nstrobe = 0, ndone = 0;
    int done_cyc = 0, start_cyc = 0, inj_mode = 0;
    int strobe_cyc [$];
    logic [FW-1:0]  fit_tab [PS];
    logic [FW-1:0]  reply_fit;
    logic [ILW-1:0] cap_vec2;
    bit rst_next = 0, rst_chk = 0;
`ifdef FITNESS_BEST_TRACK_EN
    logic [FW-1:0] cap_best;
    logic [AW-1:0] cap_bidx;
`endif

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        start_i = 0; cfg_wr_i = 0; pop_wr_en_i = 0;
        eval_out_valid_i = 0; rst_i = 0;
        if (rst_chk) begin
            chk("busy_after_rst", busy_o, 0);
            rst_chk = 0;
        end
        if (rst_next) begin
            rst_i = 1; rst_next = 0; rst_chk = 1;
        end
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                eval_out_valid_i = 1;
                eval_self_fit_i  = reply_fit;
            end
        end
        if (eval_in_valid_o) begin
            strobe_cyc.push_back(cyc);
            cd = eval_d;
            reply_fit = (nstrobe < PS) ? fit_tab[nstrobe] : '0;
            nstrobe++;
            if (inj_mode == 2) begin
                eval_out_valid_i = 1;
                eval_self_fit_i  = 10'd777;
                if (nstrobe == 3) cap_vec2 = eval_individual_vec_o;
            end
            if (inj_mode == 3 && nstrobe == 4) rst_next = 1;
        end
        if (done_o) begin
            ndone++;
            done_cyc = cyc;
            if (inj_mode == 1) start_i = 1;
`ifdef FITNESS_BEST_TRACK_EN
            if (inj_mode == 2) begin
                cap_best = best_fit_o;
                cap_bidx = best_idx_o;
            end
`endif
        end
        if (inj_mode == 1 && cyc == start_cyc + 5) begin
            pop_wr_en_i = 1; pop_wr_addr_i = 3'd2;
            pop_wr_data_i = '1;
            cfg_wr_i = 1; self_energy_vec_i = '0;
            interact_matrix_i = '0;
            start_i = 1;
        end
    endtask

    task automatic run_sweep(input int d, input int mode,
                             input bit want_done);
        eval_d = d; inj_mode = mode; nstrobe = 0; ndone = 0; cd = 0;
        strobe_cyc.delete();
        step();
        start_i = 1;
        start_cyc = cyc;
        for (int i = 0; i < 100; i++) begin
            step();
            if (want_done && ndone > 0) break;
        end
        if (want_done) chk("sweep_done_seen", ndone, 1);
        inj_mode = 0;
    endtask

    initial begin
        rst_i = 1; cfg_wr_i = 0; start_i = 0;
        self_energy_vec_i = '0; interact_matrix_i = '0;
        pop_wr_en_i = 0; pop_wr_addr_i = '0; pop_wr_data_i = '0;
        eval_out_valid_i = 0; eval_self_fit_i = '0; fit_rd_addr_i = '0;
        cap_vec2 = '0; reply_fit = '0;

        step(); rst_i = 1;
        step();
        chk_en = 1;
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_rd", fit_rd_data_o, 0);

        cfg_wr_i = 1;
        self_energy_vec_i = 12'hA53;
        interact_matrix_i = 36'h9ABCD1234;
        for (int n = 0; n < PS; n++) begin
            step();
            pop_wr_en_i = 1;
            pop_wr_addr_i = AW'(n);
            pop_wr_data_i = mkind(n);
        end
        step();
        chk("cfg_se", eval_self_energy_vec_o, 12'hA53);

        for (int n = 0; n < PS; n++) fit_tab[n] = FW'(10 * n);
        run_sweep(3, 0, 1);
        chk("s1_strobes", nstrobe, 8);
        chk("s1_dones", ndone, 1);
        fit_rd_addr_i = 3'd5;
        step();
        chk("s1_score5", fit_rd_data_o, 50);

        for (int n = 0; n < PS; n++) fit_tab[n] = FW'(100 + n);
        run_sweep(1, 1, 1);
        chk("s2_strobes", nstrobe, 8);
        if (strobe_cyc.size() == PS) begin
            for (int i = 1; i < PS; i++) begin
                chk("s2_spacing", strobe_cyc[i] - strobe_cyc[i-1], 2);
            end
        end
        chk("s2_latency", done_cyc - start_cyc, 17);
        step();
        chk("s2_idle", busy_o, 0);
        chk("s2_cfg_se", eval_self_energy_vec_o, 12'hA53);
        chk("s2_cfg_im", eval_interact_matrix_o, 36'h9ABCD1234);

        eval_out_valid_i = 1;
        eval_self_fit_i = 10'd999;
        fit_rd_addr_i = 3'd3;
        step();
        step();
        chk("idle_spur_score3", fit_rd_data_o, 103);

        fit_tab = '{10'd9, 10'd4, 10'd7, 10'd4,
                    10'd12, 10'd5, 10'd6, 10'd8};
        run_sweep(2, 2, 1);
        chk("s3_strobes", nstrobe, 8);
        chk("s3_ind2", cap_vec2, mkind(2));
`ifdef FITNESS_BEST_TRACK_EN
        chk("s3_best_fit", cap_best, 4);
        chk("s3_best_idx", cap_bidx, 1);
`endif
        fit_rd_addr_i = 3'd4;
        step();
        chk("s3_score4", fit_rd_data_o, 12);
        fit_rd_addr_i = 3'd0;
        step();
        chk("s3_score0", fit_rd_data_o, 9);

        for (int n = 0; n < PS; n++) fit_tab[n] = FW'(50 + n);
        run_sweep(3, 3, 0);
        chk("s4_strobes", nstrobe, 4);
        chk("s4_idle", busy_o, 0);
        for (int a = 0; a < PS; a++) begin
            fit_rd_addr_i = AW'(a);
            step();
            chk("rst_score", fit_rd_data_o, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
